// File: rtl/db9_md_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : db9_md_pad_scanner
// Description : Scans one or two Sega Mega Drive 3/6-button pads on the DB9
//               user port. Drives the pad SELECT line and the port split mux.
//               Samples the active-low pad pins on the last cycle of each
//               SELECT phase. Publishes active-high button words atomically,
//               one per completed eight-phase sequence.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   PHASE_CYC  clk_sys cycles per SELECT phase (>= 2)
//   IDLE_CYC   cycles SELECT is held high between sequences (>= 2)
// Ports:
//   clk_sys    in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   joy_in     in   6   pad pins, active-low: [0]Up [1]Down [2]Left [3]Right
//                       [4]B/A [5]C/Start
//   joy_mdsel  out  1   pad SELECT (pin 7)
//   joy_split  out  1   port mux: 0 = player 1, 1 = player 2
//   joystick1  out  16  player 1: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start
//                       [8]Z [9]Y [10]X [11]Mode [12]present [13]six_btn
//   joystick2  out  16  player 2, same layout
// Configuration macro:
//   DB9_SECOND_PORT_EN  defined   : players alternate, joy_split toggles at
//                                   every commit
//                       undefined : joy_split tied 0, joystick2 tied 0, every
//                                   commit targets joystick1
// ============================================================================
module db9_md_pad_scanner #(
    parameter int PHASE_CYC = 400,
    parameter int IDLE_CYC  = 100000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2
);

    // One counter serves both the idle wait and the phase timing.
    localparam int c_CNT_MAX = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_PHASE_LAST = c_CNT_W'(PHASE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_LAST  = c_CNT_W'(IDLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_phase;
    logic [5:0]           r_pin;
    logic [13:0]          r_cap;
    logic                 r_mdsel;
    logic [15:0]          r_joy1;

    logic [5:0]           w_n;
    logic                 w_phase_end;
    logic [15:0]          w_word;

    // Active-high view of the registered pins.
    assign w_n         = ~r_pin;
    assign w_phase_end = (r_cnt == c_PHASE_LAST);
    // An absent pad publishes an all-zero word regardless of stray bits.
    assign w_word      = r_cap[12] ? {2'b00, r_cap} : 16'h0000;

`ifdef DB9_SECOND_PORT_EN
    logic        r_split;
    logic [15:0] r_joy2;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_phase <= 3'd0;
            r_pin   <= 6'h3F;
            r_cap   <= '0;
            r_mdsel <= 1'b1;
            r_joy1  <= 16'h0000;
`ifdef DB9_SECOND_PORT_EN
            r_split <= 1'b0;
            r_joy2  <= 16'h0000;
`endif
        end else begin
            // Single input register: with PHASE_CYC >= 2 the value read on
            // the last phase cycle always reflects the current SELECT level.
            r_pin <= joy_in;

            case (r_state)
                ST_IDLE: begin
                    if (r_cnt == c_IDLE_LAST) begin
                        r_cnt   <= '0;
                        r_phase <= 3'd0;
                        r_mdsel <= 1'b0;
                        r_cap   <= '0;
                        r_state <= ST_SCAN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (w_phase_end) begin
                        r_cnt <= '0;
                        case (r_phase)
                            3'd0: begin
                                r_cap[12] <= w_n[2] & w_n[3];
                                r_cap[6]  <= w_n[4];
                                r_cap[7]  <= w_n[5];
                            end
                            3'd1: begin
                                r_cap[3] <= w_n[0];
                                r_cap[2] <= w_n[1];
                                r_cap[1] <= w_n[2];
                                r_cap[0] <= w_n[3];
                                r_cap[4] <= w_n[4];
                                r_cap[5] <= w_n[5];
                            end
                            3'd4: begin
                                r_cap[13] <= &w_n[3:0];
                            end
                            3'd5: begin
                                // Extra buttons only exist on a pad that
                                // identified itself at the previous phase.
                                if (r_cap[13]) begin
                                    r_cap[8]  <= w_n[0];
                                    r_cap[9]  <= w_n[1];
                                    r_cap[10] <= w_n[2];
                                    r_cap[11] <= w_n[3];
                                end
                            end
                            default: begin
                            end
                        endcase

                        if (r_phase == 3'd7) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_phase <= r_phase + 3'd1;
                            // SELECT follows bit 0 of the next phase.
                            r_mdsel <= ~r_phase[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_COMMIT: begin
`ifdef DB9_SECOND_PORT_EN
                    if (r_split) begin
                        r_joy2 <= w_word;
                    end else begin
                        r_joy1 <= w_word;
                    end
                    // The new split value holds through the whole idle
                    // period, so the mux settles before the next SELECT edge.
                    r_split <= ~r_split;
`else
                    r_joy1 <= w_word;
`endif
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_cnt   <= '0;
                    r_mdsel <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign joy_mdsel = r_mdsel;
    assign joystick1 = r_joy1;

`ifdef DB9_SECOND_PORT_EN
    assign joy_split = r_split;
    assign joystick2 = r_joy2;
`else
    assign joy_split = 1'b0;
    assign joystick2 = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_db9_md_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_db9_md_pad_scanner
// Description : Directed bench for db9_md_pad_scanner with PHASE_CYC=4,
//               IDLE_CYC=16. A behavioural 3/6-button pad model per port is
//               driven by joy_mdsel falling edges; the port is picked by
//               joy_split.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db9_md_pad_scanner;

    localparam int PHASE_CYC = 4;
    localparam int IDLE_CYC  = 16;

    // Button bit positions in the published word layout.
    localparam logic [11:0] c_R     = 12'h001;
    localparam logic [11:0] c_C     = 12'h020;
    localparam logic [11:0] c_UP    = 12'h008;
    localparam logic [11:0] c_B     = 12'h010;
    localparam logic [11:0] c_START = 12'h080;
    localparam logic [11:0] c_X     = 12'h400;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;

    int n_cmp = 0;
    int n_bad = 0;

    // Pad model state
    logic [11:0] btn1 = 12'h000;
    logic [11:0] btn2 = 12'h000;
    logic        six1 = 1'b0;
    logic        six2 = 1'b0;
    logic        pres1 = 1'b0;
    logic        pres2 = 1'b0;
    int          lows = 0;
    int          hi_cnt = 0;
    logic        prev_sel = 1'b1;

    db9_md_pad_scanner #(
        .PHASE_CYC (PHASE_CYC),
        .IDLE_CYC  (IDLE_CYC)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy_in    (joy_in),
        .joy_mdsel (joy_mdsel),
        .joy_split (joy_split),
        .joystick1 (joystick1),
        .joystick2 (joystick2)
    );

    always #5 clk_sys = ~clk_sys;

    // Pad internal counter: counts SELECT falling edges, clears after SELECT
    // has been high long enough (pad timeout).
    always @(negedge clk_sys) begin
        if (prev_sel && !joy_mdsel) lows = lows + 1;
        if (joy_mdsel) hi_cnt = hi_cnt + 1;
        else           hi_cnt = 0;
        if (hi_cnt > 8) lows = 0;
        prev_sel = joy_mdsel;
    end

    function automatic logic [5:0] pad_pins(input logic sel, input int lw,
                                            input logic [11:0] b, input logic six,
                                            input logic pres);
        logic [5:0] n;
        if (!sel) begin
            if (six && lw == 3)      n = {b[7], b[6], 4'b1111};
            else if (six && lw == 4) n = {b[7], b[6], 4'b0000};
            else                     n = {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
        end else if (six && lw == 3) begin
            n = {b[5], b[4], b[11], b[10], b[9], b[8]};
        end else begin
            n = {b[5], b[4], b[0], b[1], b[2], b[3]};
        end
        return pres ? ~n : 6'h3F;
    endfunction

    assign joy_in = joy_split ? pad_pins(joy_mdsel, lows, btn2, six2, pres2)
                              : pad_pins(joy_mdsel, lows, btn1, six1, pres1);

    // Advance n rising edges and land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // Count cycles from the current point until SELECT falls (bounded).
    task automatic wait_sel_fall(output int c);
        c = 0;
        while (joy_mdsel && c < 60) begin
            step(1);
            c = c + 1;
        end
    endtask

    task automatic test_reset;
        int c;
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        n_cmp++; if (joy_mdsel !== 1'b1) begin n_bad++; $display("FAIL rst_mdsel got %b want 1", joy_mdsel); end
        n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL rst_split got %b want 0", joy_split); end
        n_cmp++; if (joystick1 !== 16'h0000) begin n_bad++; $display("FAIL rst_joy1 got %h want 0000", joystick1); end
        n_cmp++; if (joystick2 !== 16'h0000) begin n_bad++; $display("FAIL rst_joy2 got %h want 0000", joystick2); end
        reset = 1'b0;
        wait_sel_fall(c);
        n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL rst_first_fall got %0d want 16", c); end
    endtask

    // Starts at edge 16 after reset release; first commit lands at edge 49.
    task automatic test_six_button;
        step(32);
        n_cmp++; if (joystick1 !== 16'h0000) begin n_bad++; $display("FAIL six_pre got %h want 0000", joystick1); end
        step(1);
        n_cmp++; if (joystick1 !== 16'h3480) begin n_bad++; $display("FAIL six_joy1 got %h want 3480", joystick1); end
        n_cmp++; if (joystick2 !== 16'h0000) begin n_bad++; $display("FAIL six_joy2 got %h want 0000", joystick2); end
`ifdef DB9_SECOND_PORT_EN
        n_cmp++; if (joy_split !== 1'b1) begin n_bad++; $display("FAIL six_split got %b want 1", joy_split); end
`else
        n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL six_split got %b want 0", joy_split); end
`endif
    endtask

`ifdef DB9_SECOND_PORT_EN
    task automatic test_three_button;
        btn2 = c_UP | c_C; six2 = 1'b0; pres2 = 1'b1;
        step(48);
        n_cmp++; if (joystick2 !== 16'h0000) begin n_bad++; $display("FAIL three_pre got %h want 0000", joystick2); end
        step(1);
        n_cmp++; if (joystick2 !== 16'h1028) begin n_bad++; $display("FAIL three_joy2 got %h want 1028", joystick2); end
        n_cmp++; if (joystick2[11:8] !== 4'h0) begin n_bad++; $display("FAIL three_ext got %h want 0", joystick2[11:8]); end
        n_cmp++; if (joystick1 !== 16'h3480) begin n_bad++; $display("FAIL three_joy1_hold got %h want 3480", joystick1); end
        n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL three_split got %b want 0", joy_split); end
    endtask

    task automatic test_no_pad;
        btn1 = c_R; six1 = 1'b0; pres1 = 1'b1;
        pres2 = 1'b0;
        step(49);
        n_cmp++; if (joystick1 !== 16'h1001) begin n_bad++; $display("FAIL nopad_joy1 got %h want 1001", joystick1); end
        n_cmp++; if (joy_split !== 1'b1) begin n_bad++; $display("FAIL nopad_split got %b want 1", joy_split); end
        step(49);
        n_cmp++; if (joystick2 !== 16'h0000) begin n_bad++; $display("FAIL nopad_joy2 got %h want 0000", joystick2); end
        n_cmp++; if (joystick1 !== 16'h1001) begin n_bad++; $display("FAIL nopad_joy1_hold got %h want 1001", joystick1); end
    endtask
`else
    task automatic test_three_button;
        btn1 = c_UP | c_C; six1 = 1'b0; pres1 = 1'b1;
        step(48);
        n_cmp++; if (joystick1 !== 16'h3480) begin n_bad++; $display("FAIL three_pre got %h want 3480", joystick1); end
        step(1);
        n_cmp++; if (joystick1 !== 16'h1028) begin n_bad++; $display("FAIL three_joy1 got %h want 1028", joystick1); end
        n_cmp++; if (joystick1[11:8] !== 4'h0) begin n_bad++; $display("FAIL three_ext got %h want 0", joystick1[11:8]); end
    endtask

    task automatic test_no_pad;
        pres1 = 1'b0;
        step(49);
        n_cmp++; if (joystick1 !== 16'h0000) begin n_bad++; $display("FAIL nopad_joy1 got %h want 0000", joystick1); end
        btn1 = c_R; six1 = 1'b0; pres1 = 1'b1;
        step(49);
        n_cmp++; if (joystick1 !== 16'h1001) begin n_bad++; $display("FAIL right_joy1 got %h want 1001", joystick1); end
        step(20);
        n_cmp++; if (joystick1 !== 16'h1001) begin n_bad++; $display("FAIL right_mid got %h want 1001", joystick1); end
        step(29);
        n_cmp++; if (joystick1 !== 16'h1001) begin n_bad++; $display("FAIL right_next got %h want 1001", joystick1); end
    endtask
`endif

    // Entered on a commit edge C before a player-1 sequence. Phase 5 spans
    // edges C+37..C+40; reset is asserted in the middle of it.
    task automatic test_reset_mid;
        int c;
        btn1 = c_R | c_B; six1 = 1'b0; pres1 = 1'b1;
        step(38);
        n_cmp++; if (joystick1 !== 16'h1001) begin n_bad++; $display("FAIL mid_before got %h want 1001", joystick1); end
        reset = 1'b1;
        step(2);
        n_cmp++; if (joystick1 !== 16'h0000) begin n_bad++; $display("FAIL mid_joy1 got %h want 0000", joystick1); end
        n_cmp++; if (joystick2 !== 16'h0000) begin n_bad++; $display("FAIL mid_joy2 got %h want 0000", joystick2); end
        n_cmp++; if (joy_mdsel !== 1'b1) begin n_bad++; $display("FAIL mid_mdsel got %b want 1", joy_mdsel); end
        n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL mid_split got %b want 0", joy_split); end
        reset = 1'b0;
        wait_sel_fall(c);
        n_cmp++; if (c !== 16) begin n_bad++; $display("FAIL mid_restart got %0d want 16", c); end
        step(32);
        n_cmp++; if (joystick1 !== 16'h0000) begin n_bad++; $display("FAIL mid_nopartial got %h want 0000", joystick1); end
        step(1);
        n_cmp++; if (joystick1 !== 16'h1011) begin n_bad++; $display("FAIL mid_commit got %h want 1011", joystick1); end
    endtask

`ifdef DB9_SECOND_PORT_EN
    // Alternate players: P2 holds B (3-button), P1 keeps Right+B.
    task automatic test_back_to_back;
        btn2 = c_B; six2 = 1'b0; pres2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(49);
            if (i % 2 == 0) begin
                n_cmp++; if (joystick2 !== 16'h1010) begin n_bad++; $display("FAIL b2b_joy2[%0d] got %h want 1010", i, joystick2); end
                n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL b2b_split[%0d] got %b want 0", i, joy_split); end
            end else begin
                n_cmp++; if (joystick1 !== 16'h1011) begin n_bad++; $display("FAIL b2b_joy1[%0d] got %h want 1011", i, joystick1); end
                n_cmp++; if (joy_split !== 1'b1) begin n_bad++; $display("FAIL b2b_split[%0d] got %b want 1", i, joy_split); end
            end
        end
    endtask
`else
    // Ten sequences on player 1 with a new 3-button pattern each time.
    task automatic test_back_to_back;
        logic [11:0] pats [10];
        logic [15:0] exps [10];
        logic [15:0] prev;
        pats = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010,
                 12'h020, 12'h040, 12'h080, 12'h0F3, 12'h000};
        exps = '{16'h1001, 16'h1002, 16'h1004, 16'h1008, 16'h1010,
                 16'h1020, 16'h1040, 16'h1080, 16'h10F3, 16'h1000};
        prev = 16'h1011;
        six1 = 1'b0; pres1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn1 = pats[i];
            step(48);
            n_cmp++; if (joystick1 !== prev) begin n_bad++; $display("FAIL b2b_hold[%0d] got %h want %h", i, joystick1, prev); end
            n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL b2b_split_pre[%0d] got %b want 0", i, joy_split); end
            step(1);
            n_cmp++; if (joystick1 !== exps[i]) begin n_bad++; $display("FAIL b2b_joy1[%0d] got %h want %h", i, joystick1, exps[i]); end
            n_cmp++; if (joystick2 !== 16'h0000) begin n_bad++; $display("FAIL b2b_joy2[%0d] got %h want 0000", i, joystick2); end
            n_cmp++; if (joy_split !== 1'b0) begin n_bad++; $display("FAIL b2b_split[%0d] got %b want 0", i, joy_split); end
            prev = exps[i];
        end
    endtask
`endif

    initial begin
        btn1 = c_START | c_X; six1 = 1'b1; pres1 = 1'b1;
        btn2 = 12'h000;       six2 = 1'b0; pres2 = 1'b0;
        test_reset;
        test_six_button;
        test_three_button;
        test_no_pad;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
